rr_arbiter: RTL

Parametrised N-way arbiter with registered one-hot grant, hold-until-release semantics, a bounded-tenure preemption counter and round-robin fairness. It is the sequential successor to the combinational lowest-set-bit arbiter. It sits between N requesters and one shared resource (bus, UART TX, SPI master) in the icestick designs. Selection logic reuses the lowest-set-bit isolation, I & ~(I-1), applied to a rotated/masked request vector.

---
 rtl/rr_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way arbiter with a registered one-hot grant, hold-until-release,
// bounded tenure (MAX_HOLD) and round-robin fairness.
// Optional feature macro: RR_ARB_ROUND_ROBIN_EN. When it is defined, the
// priority pointer rotates past each new grant. When it is undefined, the
// pointer stays at 0 and the arbiter gives fixed priority to the lowest index.
module rr_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 4
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [N-1:0]         REQ,
   output logic [N-1:0]         GNT,
   output logic                 GNT_VALID,
   output logic [$clog2(N)-1:0] GNT_ID
);

   localparam int IDW = $clog2(N);
   localparam int CW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_HOLD);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [N-1:0]  VEC_ONE = N'(1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state_q, state_n;
   logic [N-1:0]    gnt_q, gnt_n;
   logic            valid_q;
   logic [IDW-1:0]  id_q, id_n;
   logic [IDW-1:0]  ptr_q, ptr_n;
   logic [CW-1:0]   cnt_q, cnt_n;
   logic [N-1:0]    win_all, win_other;
   logic            new_grant;
   logic [N-1:0]    new_vec;

   // Lowest set bit at index >= p, falling back to the lowest set bit overall.
   function automatic logic [N-1:0] arb(input logic [N-1:0] v, input logic [IDW-1:0] p);
      logic [N-1:0] hi;
      hi = v & ({N{1'b1}} << p);
      if (hi != '0)
         return hi & (~hi + VEC_ONE);
      return v & (~v + VEC_ONE);
   endfunction

   // Binary index of a one-hot vector; 0 when the vector is empty.
   function automatic logic [IDW-1:0] idx_of(input logic [N-1:0] oh);
      logic [IDW-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < N; i++)
         if (oh[i])
            r = IDW'(i);
      return r;
   endfunction

   assign win_all   = arb(REQ, ptr_q);
   assign win_other = arb(REQ & ~gnt_q, ptr_q);

   // Next-state logic: release, expiry and hold decisions, plus pointer update.
   always_comb begin
      state_n   = state_q;
      gnt_n     = gnt_q;
      cnt_n     = cnt_q;
      new_grant = 1'b0;
      new_vec   = '0;

      unique case (state_q)
         IDLE: begin
            if (REQ != '0) begin
               new_grant = 1'b1;
               new_vec   = win_all;
            end
         end
         BUSY: begin
            if ((REQ & gnt_q) == '0) begin
               // Release takes precedence over a simultaneous expiry.
               if (win_all != '0) begin
                  new_grant = 1'b1;
                  new_vec   = win_all;
               end else begin
                  state_n = IDLE;
                  gnt_n   = '0;
                  cnt_n   = '0;
               end
            end else if ((MAX_HOLD != 0) && (cnt_q == MAX_CNT)) begin
               if (win_other != '0) begin
                  new_grant = 1'b1;
                  new_vec   = win_other;
               end else begin
                  cnt_n = CNT_ONE;
               end
            end else if ((MAX_HOLD != 0) && (cnt_q != MAX_CNT)) begin
               cnt_n = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
            cnt_n   = '0;
         end
      endcase

      if (new_grant) begin
         state_n = BUSY;
         gnt_n   = new_vec;
         cnt_n   = CNT_ONE;
      end

      id_n = idx_of(gnt_n);

`ifdef RR_ARB_ROUND_ROBIN_EN
      ptr_n = ptr_q;
      if (new_grant)
         ptr_n = (id_n == IDW'(N - 1)) ? '0 : id_n + IDW'(1);
`else
      ptr_n = '0;
`endif
   end

   // State and output registers; synchronous reset dominates.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         valid_q <= 1'b0;
         id_q    <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_n;
         gnt_q   <= gnt_n;
         valid_q <= (gnt_n != '0);
         id_q    <= id_n;
         ptr_q   <= ptr_n;
         cnt_q   <= cnt_n;
      end
   end

   assign GNT       = gnt_q;
   assign GNT_VALID = valid_q;
   assign GNT_ID    = id_q;

endmodule
